// File: rtl/mux_nx1_pipe.sv
// N-to-1 channel mux with a single-entry registered output buffer and runtime select.
// Optional auto-advance of the selected channel on each accept: define MUX_NX1_PIPE_SCAN_EN.
module mux_nx1_pipe #(
  parameter int N_IN  = 6,
  parameter int WIDTH = 1,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  sel_wr,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  scan_mode,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      sel_cur,
  output logic                  sel_err,
  output logic [15:0]           xfer_cnt
);

  // Inputs are padded to a power of two so a select index can never address past the vectors.
  localparam int N_PAD = 1 << SEL_W;
  localparam logic [SEL_W:0] N_IN_W = (SEL_W+1)'(N_IN);

  logic [SEL_W-1:0]        sel_p1;
  logic                    vld_p1;
  logic [WIDTH-1:0]        data_p1;
  logic                    err_p1;
  logic [15:0]             cnt_p1;

  logic [N_PAD-1:0]        vld_pad;
  logic [N_PAD*WIDTH-1:0]  data_pad;
  logic [N_PAD-1:0]        one_hot;
  logic                    drain_ok;
  logic                    acc_p0;
  logic [WIDTH-1:0]        data_p0;
  logic                    sel_ok;
  logic [SEL_W-1:0]        sel_nxt;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(N_IN - 1)) ? '0 : s + 1'b1;
  endfunction

  // Stage p0: channel select, handshake and select-update decode
  always_comb begin
    vld_pad  = N_PAD'(in_valid);
    data_pad = (N_PAD*WIDTH)'(in_data);
    one_hot  = N_PAD'(1) << sel_p1;
    drain_ok = !vld_p1 || out_ready;
    in_ready = drain_ok ? one_hot[N_IN-1:0] : '0;
    acc_p0   = drain_ok && vld_pad[sel_p1];
    data_p0  = data_pad[sel_p1*WIDTH +: WIDTH];
    sel_ok   = {1'b0, sel_in} < N_IN_W;
    sel_nxt  = sel_p1;
    if (sel_wr && sel_ok) begin
      sel_nxt = sel_in;
    end
`ifdef MUX_NX1_PIPE_SCAN_EN
    else if (scan_mode && acc_p0) begin
      sel_nxt = wrap_inc(sel_p1);
    end
`endif
  end

`ifndef MUX_NX1_PIPE_SCAN_EN
  logic unused_scan;
  assign unused_scan = scan_mode;
`endif

  // Stage p1: output buffer, select register, status
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      err_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      if (acc_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        cnt_p1  <= cnt_p1 + 16'd1;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
      sel_p1 <= sel_nxt;
      err_p1 <= sel_wr && !sel_ok;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign sel_cur   = sel_p1;
  assign sel_err   = err_p1;
  assign xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe (N_IN=6, WIDTH=8): directed steps plus random traffic
// compared against a transaction-level reference model.
module tb_mux_nx1_pipe;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            sel_wr;
  logic [SW-1:0]   sel_in;
  logic            scan_mode;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   sel_cur;
  logic            sel_err;
  logic [15:0]     xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_init = 0;
  bit       m_valid;
  int       m_data;
  int       m_sel;
  bit       m_err;
  int       m_cnt;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.N_IN(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_wr(sel_wr), .sel_in(sel_in), .scan_mode(scan_mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_cur(sel_cur), .sel_err(sel_err),
    .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int val);
    in_data[ch*W +: W] = W'(val);
  endtask

  // One clock: check combinational ready, advance the model, check registered outputs.
  task automatic cycle();
    bit drain_ok, acc;
    int exp_rdy;
    #1;
    if (m_init) begin
      drain_ok = !m_valid || out_ready;
      exp_rdy  = drain_ok ? (1 << m_sel) : 0;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    end
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_err = 0; m_cnt = 0;
      m_init  = 1;
    end else begin
      drain_ok = !m_valid || out_ready;
      acc      = drain_ok && in_valid[m_sel];
      if (acc) begin
        m_valid = 1;
        m_data  = int'(in_data[m_sel*W +: W]);
        m_cnt   = (m_cnt + 1) % 65536;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_err = sel_wr && (int'(sel_in) >= N);
      if (sel_wr && int'(sel_in) < N) m_sel = int'(sel_in);
`ifdef MUX_NX1_PIPE_SCAN_EN
      else if (scan_mode && acc) m_sel = (m_sel + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("sel_cur",   64'(sel_cur),   64'(m_sel));
    chk("sel_err",   64'(sel_err),   64'(m_err));
    chk("xfer_cnt",  64'(xfer_cnt),  64'(m_cnt));
  endtask

  task automatic idle();
    rst = 0; sel_wr = 0; sel_in = '0; scan_mode = 0; in_valid = '0; out_ready = 0;
  endtask

  initial begin
    logic [N-1:0] held;
    in_data = {N*W{1'b1}};
    idle();
    // Reset with busy inputs
    rst = 1; in_valid = '1; out_ready = 1; sel_wr = 1; sel_in = 3'd4;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data",  64'(out_data),  64'd0);
    chk("reset_cnt",   64'(xfer_cnt),  64'd0);
    idle();

    // Select ch3, transfer 0xA5
    sel_wr = 1; sel_in = 3'd3;
    cycle();
    sel_wr = 0;
    for (int i = 0; i < N; i++) set_ch(i, 16 * i);
    set_ch(3, 8'hA5); in_valid = 6'b001000; out_ready = 1;
    cycle();
    chk("req032_data",  64'(out_data),  64'hA5);
    chk("req032_valid", 64'(out_valid), 64'd1);
    chk("req032_cnt",   64'(xfer_cnt),  64'd1);
    in_valid = '0;
    cycle();

    // Out-of-range selects rejected
    sel_wr = 1; sel_in = 3'd6; in_valid = 6'b100000;
    cycle();
    chk("req033_err", 64'(sel_err), 64'd1);
    chk("req033_sel", 64'(sel_cur), 64'd3);
    sel_in = 3'd7;
    cycle();
    sel_wr = 0;
    cycle();
    chk("req033_err_clear", 64'(sel_err), 64'd0);
    chk("req033_no_ch5",    64'(sel_cur), 64'd3);

    // Backpressure then back-to-back drain on ch0
    sel_wr = 1; sel_in = 3'd0;
    cycle();
    sel_wr = 0; in_valid = 6'b000001; set_ch(0, 8'h11); out_ready = 1;
    cycle();
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 8'h20 + k);
      cycle();
      chk("req034_frozen", 64'(out_data), 64'h11);
      chk("req034_ready0", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 8'h30 + k);
      cycle();
      chk("req034_stream", 64'(out_data), 64'(8'h30 + k));
      chk("req034_nobubble", 64'(out_valid), 64'd1);
    end
    chk("req034_cnt", 64'(xfer_cnt), 64'd6);

    // Scan mode round robin (advance only when the feature is built in)
    in_valid = '1; scan_mode = 1;
    for (int k = 0; k < N; k++) set_ch(k, 8'hC0 + k);
    for (int k = 0; k < 8; k++) cycle();
    scan_mode = 0;

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      sel_wr    = ($urandom_range(0, 3) == 0);
      sel_in    = SW'($urandom_range(0, 7));
      scan_mode = $urandom_range(0, 1);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_ch(i, $urandom_range(0, 255));
      cycle();
    end
    idle();

    // Reset while holding a word with count 5
    rst = 1; cycle(); rst = 0;
    in_valid = 6'b000001; out_ready = 1;
    for (int k = 0; k < 5; k++) begin set_ch(0, 8'h50 + k); cycle(); end
    out_ready = 0; in_valid = '0;
    cycle();
    chk("req036_pre_cnt",   64'(xfer_cnt),  64'd5);
    chk("req036_pre_valid", 64'(out_valid), 64'd1);
    rst = 1; in_valid = '1; out_ready = 1;
    cycle();
    chk("req036_valid", 64'(out_valid), 64'd0);
    chk("req036_data",  64'(out_data),  64'd0);
    chk("req036_sel",   64'(sel_cur),   64'd0);
    chk("req036_cnt",   64'(xfer_cnt),  64'd0);
    idle();

    // Counter wrap after 65536 accepts
    in_valid = '1; out_ready = 1;
    for (int k = 0; k < 65535; k++) begin
      held = N'($urandom);
      set_ch(k % N, int'(held));
      cycle();
    end
    chk("wrap_ffff", 64'(xfer_cnt), 64'hFFFF);
    cycle();
    chk("wrap_zero", 64'(xfer_cnt), 64'd0);
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 Parameter N_IN, default 6, number of input channels (2..64).
REQ-002 Parameter WIDTH, default 1, data width per channel (1..64).
REQ-003 Derived localparam SEL_W = max(1, clog2(N_IN)), not overridable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N_IN*WIDTH  flat channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_IN  per-channel valid.
REQ-008 in_ready  output  N_IN  per-channel ready, combinational.
REQ-009 sel_wr  input  1  select-load strobe.
REQ-010 sel_in  input  SEL_W  requested channel index.
REQ-011 scan_mode  input  1  auto-advance enable; effective only per REQ-030.
REQ-012 out_data  output  WIDTH  registered output word.
REQ-013 out_valid  output  1  out_data holds an unconsumed word.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 sel_cur  output  SEL_W  currently selected channel, registered.
REQ-016 sel_err  output  1  one-cycle pulse on rejected select.
REQ-017 xfer_cnt  output  16  count of accepted input transfers.

Function
REQ-018 Block SHALL hold a single-entry output buffer (out_data, out_valid).
REQ-019 in_ready[i] SHALL equal (i == sel_cur) AND (NOT out_valid OR out_ready); all other bits 0.
REQ-020 Accept occurs when in_valid[sel_cur] AND in_ready[sel_cur]; the next cycle SHALL show out_data = channel sel_cur data and out_valid = 1 (1-cycle latency).
REQ-021 When out_valid AND out_ready with no accept, out_valid SHALL clear next cycle; out_data SHALL hold its value.
REQ-022 Simultaneous drain and accept SHALL replace the word with no bubble (full throughput).
REQ-023 While out_valid = 1 and out_ready = 0, out_data SHALL stay stable and in_ready SHALL be all 0.
REQ-024 sel_wr with sel_in < N_IN SHALL load sel_cur next cycle.
REQ-025 sel_wr with sel_in >= N_IN SHALL leave sel_cur unchanged and pulse sel_err for exactly one cycle.
REQ-026 An accept in the same cycle as sel_wr SHALL use the old sel_cur; the buffered word is unaffected by select changes.
REQ-027 xfer_cnt SHALL increment by 1 per accept and wrap 0xFFFF -> 0x0000.
REQ-028 in_data of unselected channels SHALL never reach out_data.

Reset
REQ-029 With rst high at a clock edge: out_valid = 0, out_data = 0, sel_cur = 0, sel_err = 0, xfer_cnt = 0. Any buffered word is discarded and no accept occurs that cycle, regardless of the other inputs.

Configuration
REQ-030 Macro MUX_NX1_PIPE_SCAN_EN defined: when scan_mode = 1, each accept SHALL advance sel_cur to (sel_cur + 1), wrapping N_IN-1 -> 0. A valid sel_wr in the same cycle SHALL take priority over the advance.
REQ-031 Macro MUX_NX1_PIPE_SCAN_EN undefined: scan_mode SHALL be ignored and sel_cur SHALL change only via REQ-024.

Verification
REQ-032 N_IN=6, WIDTH=8, sel_wr with sel_in=3, in_data ch3=0xA5 valid, out_ready=1 -> out_data=0xA5 and out_valid=1 one cycle after the accept; xfer_cnt=1.
REQ-033 sel_in=6 with N_IN=6 -> sel_err pulses 1 cycle, sel_cur stays at its prior value, channel 5 never selected.
REQ-034 out_ready=0 for 4 cycles with ch0 valid -> out_data frozen, in_ready=0, out_valid=1; then out_ready=1 for 4 cycles -> 4 words accepted back-to-back with no bubble.
REQ-035 SCAN_EN defined, scan_mode=1, all channels valid, out_ready=1 for 8 cycles -> sel_cur sequence 0,1,2,3,4,5,0,1; out_data follows the channels in order.
REQ-036 rst asserted while out_valid=1 and xfer_cnt=0x0005 -> next cycle out_valid=0, out_data=0, sel_cur=0, xfer_cnt=0; xfer_cnt wraps 0xFFFF -> 0 after 65536 accepts.
